micro_sequencer: RTL and testbench

//   Micro-program sequencer for the microprogrammed machine. Holds the micro-PC (upc) and

---
 rtl/micro_sequencer_if.sv | 30 +++
 rtl/micro_sequencer.sv | 121 ++++++++++++
 tb/tb_micro_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer_if
// Description : Sequencing-field / micro-PC bundle between microinstruction
//               register, condition mux and the micro-sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface micro_sequencer_if #(
    parameter int ADDR_BITS = 8
);
    logic                 en;
    logic [2:0]           op;
    logic [ADDR_BITS-1:0] br_addr;
    logic                 cond;
    logic [ADDR_BITS-1:0] upc;
    logic [4:0]           depth;
    logic                 stack_ovf;
    logic                 stack_unf;

    modport master (
        output en, op, br_addr, cond,
        input  upc, depth, stack_ovf, stack_unf
    );

    modport slave (
        input  en, op, br_addr, cond,
        output upc, depth, stack_ovf, stack_unf
    );
endinterface
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Micro-PC sequencer with branch/wait opcodes and a LIFO return
//               stack for micro-subroutines; upc addresses the control store.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
    parameter int ADDR_BITS   = 8,
    parameter int STACK_DEPTH = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    micro_sequencer_if.slave  bus
);
    localparam logic [2:0] c_OP_CONT = 3'b000;
    localparam logic [2:0] c_OP_JMP  = 3'b001;
    localparam logic [2:0] c_OP_BRT  = 3'b010;
    localparam logic [2:0] c_OP_BRF  = 3'b011;
    localparam logic [2:0] c_OP_CALL = 3'b100;
    localparam logic [2:0] c_OP_RET  = 3'b101;
    localparam logic [2:0] c_OP_WAIT = 3'b110;
    localparam logic [2:0] c_OP_RST  = 3'b111;

    localparam int         c_IDX_BITS = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0] c_FULL     = 5'(STACK_DEPTH);

    logic [ADDR_BITS-1:0]  r_upc;
    logic [4:0]            r_depth;
    logic                  r_ovf;
    logic                  r_unf;
    logic [ADDR_BITS-1:0]  r_stack [STACK_DEPTH];

    logic [ADDR_BITS-1:0]  w_upc_inc;
    logic [ADDR_BITS-1:0]  w_upc_nxt;
    logic [4:0]            w_depth_nxt;
    logic                  w_ovf_nxt;
    logic                  w_unf_nxt;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [c_IDX_BITS-1:0] w_push_idx;
    logic [c_IDX_BITS-1:0] w_pop_idx;

    assign w_upc_inc  = r_upc + ADDR_BITS'(1);
    assign w_full     = (r_depth == c_FULL);
    assign w_empty    = (r_depth == 5'd0);
    assign w_push_idx = c_IDX_BITS'(r_depth);
    assign w_pop_idx  = c_IDX_BITS'(r_depth - 5'd1);

    always_comb begin
        w_upc_nxt   = r_upc;
        w_depth_nxt = r_depth;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_push      = 1'b0;
        if (bus.en) begin
            case (bus.op)
                c_OP_CONT: w_upc_nxt = w_upc_inc;
                c_OP_JMP:  w_upc_nxt = bus.br_addr;
                c_OP_BRT:  w_upc_nxt = bus.cond ? bus.br_addr : w_upc_inc;
                c_OP_BRF:  w_upc_nxt = bus.cond ? w_upc_inc : bus.br_addr;
                c_OP_CALL: begin
                    // A refused call falls through so the microprogram keeps running.
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_depth_nxt = r_depth + 5'd1;
                        w_upc_nxt   = bus.br_addr;
                    end else begin
                        w_upc_nxt   = w_upc_inc;
                        w_ovf_nxt   = 1'b1;
                    end
                end
                c_OP_RET: begin
                    if (!w_empty) begin
                        w_depth_nxt = r_depth - 5'd1;
                        w_upc_nxt   = r_stack[w_pop_idx];
                    end else begin
                        w_upc_nxt   = w_upc_inc;
                        w_unf_nxt   = 1'b1;
                    end
                end
                c_OP_WAIT: w_upc_nxt = bus.cond ? w_upc_inc : r_upc;
                c_OP_RST: begin
                    w_upc_nxt   = '0;
                    w_depth_nxt = 5'd0;
                    w_ovf_nxt   = 1'b0;
                    w_unf_nxt   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc   <= '0;
            r_depth <= 5'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_upc   <= w_upc_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_upc_inc;
        end
    end

    assign bus.upc       = r_upc;
    assign bus.depth     = r_depth;
    assign bus.stack_ovf = r_ovf;
    assign bus.stack_unf = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Self-checking bench for micro_sequencer (expected-state queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;
    localparam logic [2:0] CONT = 3'd0, JMP = 3'd1, BRT = 3'd2, BRF = 3'd3,
                           CALL = 3'd4, RET = 3'd5, WAIT = 3'd6, RST = 3'd7;

    typedef struct packed {
        logic [7:0] upc;
        logic [4:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic [2:0] op;
        logic [7:0] br;
        logic       cond;
        exp_t       e;
    } row_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    micro_sequencer_if #(.ADDR_BITS(8)) bus ();

    micro_sequencer #(.ADDR_BITS(8), .STACK_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic en, input logic [2:0] op, input logic [7:0] br,
                                input logic cond, input logic [7:0] upc, input logic [4:0] depth,
                                input logic ovf, input logic unf);
        row_t r;
        r.en = en; r.op = op; r.br = br; r.cond = cond;
        r.e.upc = upc; r.e.depth = depth; r.e.ovf = ovf; r.e.unf = unf;
        return r;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.upc = bus.upc; o.depth = bus.depth; o.ovf = bus.stack_ovf; o.unf = bus.stack_unf;
        return o;
    endfunction

    // Drive one cycle of stimulus, queue its expected result, sample 1 ns after the edge.
    task automatic drive(input row_t r);
        @(negedge clk);
        bus.en = r.en; bus.op = r.op; bus.br_addr = r.br; bus.cond = r.cond;
        sb.push_back(r.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e, got;
        bus.en = 1'b0; bus.op = CONT; bus.br_addr = 8'h00; bus.cond = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{8'h00, 5'd0, 1'b0, 1'b0});
        e = sb.pop_front(); got = observe(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_init: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
        end
        @(negedge clk); rst_n = 1'b1;
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h01, 5'd0, 0, 1));
        rows.push_back(mk(1, JMP,  8'h30, 0, 8'h30, 5'd0, 0, 1));
        rows.push_back(mk(1, CALL, 8'h10, 0, 8'h10, 5'd1, 0, 1));
        rows.push_back(mk(1, CALL, 8'h37, 1, 8'h37, 5'd2, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front(); got = observe(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_setup[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                         got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
            end
        end
        // Assert reset between edges with en high: outputs must clear without a clock.
        @(negedge clk);
        bus.en = 1'b1; bus.op = CONT;
        #2 rst_n = 1'b0;
        #1;
        sb.push_back('{8'h00, 5'd0, 1'b0, 1'b0});
        e = sb.pop_front(); got = observe(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
        end
        @(negedge clk); bus.en = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_cont();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(1, JMP,  8'hFE, 0, 8'hFE, 5'd0, 0, 0));
        rows.push_back(mk(1, CONT, 8'h00, 0, 8'hFF, 5'd0, 0, 0));
        rows.push_back(mk(1, CONT, 8'h00, 1, 8'h00, 5'd0, 0, 0));
        rows.push_back(mk(1, CONT, 8'hAA, 0, 8'h01, 5'd0, 0, 0));
        rows.push_back(mk(0, JMP,  8'hAA, 0, 8'h01, 5'd0, 0, 0));
        rows.push_back(mk(0, RST,  8'h55, 1, 8'h01, 5'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front(); got = observe(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cont[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                         got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(1, JMP, 8'h10, 0, 8'h10, 5'd0, 0, 0));
        rows.push_back(mk(1, BRT, 8'h40, 0, 8'h11, 5'd0, 0, 0));
        rows.push_back(mk(1, BRT, 8'h40, 1, 8'h40, 5'd0, 0, 0));
        rows.push_back(mk(1, BRF, 8'h60, 1, 8'h41, 5'd0, 0, 0));
        rows.push_back(mk(1, BRF, 8'h60, 0, 8'h60, 5'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front(); got = observe(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                         got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_wait();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(1, JMP, 8'h20, 0, 8'h20, 5'd0, 0, 0));
        for (int k = 0; k < 5; k++) rows.push_back(mk(1, WAIT, 8'h99, 0, 8'h20, 5'd0, 0, 0));
        rows.push_back(mk(1, WAIT, 8'h99, 1, 8'h21, 5'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front(); got = observe(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wait[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                         got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_call_ret();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(1, JMP,  8'h05, 0, 8'h05, 5'd0, 0, 0));
        rows.push_back(mk(1, CALL, 8'h80, 0, 8'h80, 5'd1, 0, 0));
        rows.push_back(mk(1, CALL, 8'h90, 1, 8'h90, 5'd2, 0, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h81, 5'd1, 0, 0));
        rows.push_back(mk(1, RET,  8'h00, 1, 8'h06, 5'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front(); got = observe(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL call_ret[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                         got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_stack_limits();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(1, JMP,  8'h10, 0, 8'h10, 5'd0, 0, 0));
        rows.push_back(mk(1, CALL, 8'h20, 0, 8'h20, 5'd1, 0, 0));
        rows.push_back(mk(1, CALL, 8'h30, 0, 8'h30, 5'd2, 0, 0));
        rows.push_back(mk(1, CALL, 8'h40, 0, 8'h40, 5'd3, 0, 0));
        rows.push_back(mk(1, CALL, 8'h50, 0, 8'h50, 5'd4, 0, 0));
        rows.push_back(mk(1, CALL, 8'h60, 0, 8'h51, 5'd4, 1, 0));
        rows.push_back(mk(1, CALL, 8'h61, 1, 8'h52, 5'd4, 1, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h41, 5'd3, 1, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h31, 5'd2, 1, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h21, 5'd1, 1, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h11, 5'd0, 1, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h12, 5'd0, 1, 1));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h13, 5'd0, 1, 1));
        rows.push_back(mk(1, CALL, 8'h70, 0, 8'h70, 5'd1, 1, 1));
        rows.push_back(mk(1, RST,  8'h77, 1, 8'h00, 5'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front(); got = observe(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL stack_limits[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                         got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(1, JMP,  8'hFF, 0, 8'hFF, 5'd0, 0, 0));
        rows.push_back(mk(1, CALL, 8'h10, 0, 8'h10, 5'd1, 0, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h00, 5'd0, 0, 0));
        rows.push_back(mk(1, CALL, 8'h30, 0, 8'h30, 5'd1, 0, 0));
        rows.push_back(mk(0, RET,  8'h00, 0, 8'h30, 5'd1, 0, 0));
        rows.push_back(mk(1, RST,  8'h00, 0, 8'h00, 5'd0, 0, 0));
        rows.push_back(mk(1, RET,  8'h00, 0, 8'h01, 5'd0, 0, 1));
        rows.push_back(mk(0, RST,  8'h00, 0, 8'h01, 5'd0, 0, 1));
        rows.push_back(mk(1, CONT, 8'h00, 1, 8'h02, 5'd0, 0, 1));
        rows.push_back(mk(1, RST,  8'h00, 0, 8'h00, 5'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front(); got = observe(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", i,
                         got.upc, got.depth, got.ovf, got.unf, e.upc, e.depth, e.ovf, e.unf);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_cont();
        test_branch();
        test_wait();
        test_call_ret();
        test_stack_limits();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
